// File: rtl/cpu_dbg_pkg.sv
// cpu_dbg_pkg: shared debug-block state encodings and width helper
package cpu_dbg_pkg;
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_POST  = 2'd2,
    ST_DONE  = 2'd3
  } dbg_state_e;
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction
endpackage

// File: rtl/trace_ram.sv
// trace_ram: sample storage with synchronous write and asynchronous read
module trace_ram #(
  parameter int DEPTH = 16,
  parameter int W     = 128,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);
  logic [W-1:0] mem [DEPTH];
  // store one whole sample row per write
  always_ff @(posedge clk) if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/cpu_trace_buffer.sv
// cpu_trace_buffer: pre/post-trigger execution trace capture with word-serial readout
module cpu_trace_buffer
  import cpu_dbg_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int DEPTH     = 16,
  parameter int NCH       = 4,
  parameter int POST_TRIG = 8
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    probe_valid,
  input  logic [NCH*DATA_W-1:0]                   probe_data,
  input  logic                                    arm,
  input  logic                                    trig_en,
  input  logic [DATA_W-1:0]                       trig_pc,
  input  logic                                    force_trig,
  output logic                                    rd_valid,
  input  logic                                    rd_ready,
  output logic [DATA_W-1:0]                       rd_data,
  output logic [(NCH > 1 ? clog2(NCH) : 1)-1:0]   rd_ch,
  output logic                                    rd_last,
  output logic [1:0]                              state,
  output logic [clog2(DEPTH+1)-1:0]               fill_count,
  output logic                                    overflow
);
  localparam int AW = clog2(DEPTH);
  localparam int CW = NCH > 1 ? clog2(NCH) : 1;
  localparam int FW = clog2(DEPTH + 1);
  localparam logic [FW-1:0] FULL    = FW'(DEPTH);
  localparam logic [CW-1:0] CH_LAST = CW'(NCH - 1);
  localparam logic [AW-1:0] PT      = AW'(POST_TRIG);
  dbg_state_e state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, post_q, post_d;
  logic [CW-1:0] ch_q, ch_d;
  logic [FW-1:0] fill_q, fill_d;
  logic ovf_q, ovf_d, we, trig;
  logic [NCH*DATA_W-1:0] row;
  trace_ram #(.DEPTH(DEPTH), .W(NCH*DATA_W), .AW(AW)) u_ram (
    .clk   (clk),
    .we    (we),
    .waddr (wr_ptr_q),
    .wdata (probe_data),
    .raddr (rd_ptr_q),
    .rdata (row)
  );
  assign trig       = force_trig || (probe_valid && trig_en && probe_data[DATA_W-1:0] == trig_pc);
  assign rd_valid   = state_q == ST_DONE && fill_q != '0;
  assign rd_last    = rd_valid && ch_q == CH_LAST && rd_ptr_q == wr_ptr_q - AW'(1);
  assign rd_data    = rd_valid ? row[ch_q*DATA_W +: DATA_W] : '0;
  assign rd_ch      = rd_valid ? ch_q : '0;
  assign state      = state_q;
  assign fill_count = fill_q;
  assign overflow   = ovf_q;
  // capture/trigger/readout sequencing; readout pointer is seeded on every DONE entry
  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    post_d   = post_q;
    ch_d     = ch_q;
    fill_d   = fill_q;
    ovf_d    = ovf_q;
    we       = 1'b0;
    case (state_q)
      ST_IDLE: if (arm) begin
        state_d  = ST_ARMED;
        fill_d   = '0;
        ovf_d    = 1'b0;
        wr_ptr_d = '0;
      end
      ST_ARMED, ST_POST: begin
        we = probe_valid;
        if (probe_valid) begin
          wr_ptr_d = wr_ptr_q + AW'(1);
          fill_d   = fill_q == FULL ? fill_q : fill_q + FW'(1);
          ovf_d    = ovf_q || fill_q == FULL;
        end
        if (state_q == ST_ARMED && trig) begin
          state_d = POST_TRIG == 0 ? ST_DONE : ST_POST;
          post_d  = PT;
        end else if (state_q == ST_POST && probe_valid) begin
          post_d  = post_q - AW'(1);
          state_d = post_q == AW'(1) ? ST_DONE : ST_POST;
        end
      end
      default: if (arm) begin
        state_d  = ST_ARMED;
        fill_d   = '0;
        ovf_d    = 1'b0;
        wr_ptr_d = '0;
      end else if (fill_q == '0) begin
        state_d = ST_IDLE;
      end else if (rd_ready) begin
        ch_d     = ch_q == CH_LAST ? '0 : ch_q + CW'(1);
        rd_ptr_d = ch_q == CH_LAST ? rd_ptr_q + AW'(1) : rd_ptr_q;
        state_d  = rd_last ? ST_IDLE : ST_DONE;
      end
    endcase
    if (state_d == ST_DONE && state_q != ST_DONE) begin
      rd_ptr_d = wr_ptr_d - fill_d[AW-1:0];
      ch_d     = '0;
    end
  end
  // state and pointer registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      post_q   <= '0;
      ch_q     <= '0;
      fill_q   <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      post_q   <= post_d;
      ch_q     <= ch_d;
      fill_q   <= fill_d;
      ovf_q    <= ovf_d;
    end
  end
endmodule

// File: tb/tb_cpu_trace_buffer.sv
// tb_cpu_trace_buffer: directed and random checks of two trace buffers (POST_TRIG 2 and 0) against a queue model
module tb_cpu_trace_buffer;
  typedef struct packed {
    logic        valid;
    logic [31:0] data;
    logic        ch;
    logic        last;
    logic [1:0]  st;
    logic [3:0]  fill;
    logic        ovf;
  } exp_t;
  logic        clk, rst, probe_valid, arm, trig_en, force_trig, rd_ready;
  logic [63:0] probe_data;
  logic [31:0] trig_pc;
  logic        rd_valid [2];
  logic [31:0] rd_data [2];
  logic        rd_ch [2];
  logic        rd_last [2];
  logic [1:0]  st [2];
  logic [3:0]  fc [2];
  logic        ovf [2];
  logic [32:0] got0 [$];
  logic [32:0] got1 [$];
  int          errors = 0;
  int          checks = 0;
  initial clk = 1'b0;
  always #5 clk = ~clk;
  for (genvar g = 0; g < 2; g++) begin : lane
    localparam int PT = g == 0 ? 2 : 0;
    cpu_trace_buffer #(.DATA_W(32), .DEPTH(8), .NCH(2), .POST_TRIG(PT)) u_dut (
      .clk         (clk),
      .rst         (rst),
      .probe_valid (probe_valid),
      .probe_data  (probe_data),
      .arm         (arm),
      .trig_en     (trig_en),
      .trig_pc     (trig_pc),
      .force_trig  (force_trig),
      .rd_valid    (rd_valid[g]),
      .rd_ready    (rd_ready),
      .rd_data     (rd_data[g]),
      .rd_ch       (rd_ch[g]),
      .rd_last     (rd_last[g]),
      .state       (st[g]),
      .fill_count  (fc[g]),
      .overflow    (ovf[g])
    );
    int          ms, w, post;
    logic        movf;
    logic [63:0] q [$];
    exp_t        e;
    always @(posedge clk) begin : mdl
      logic [63:0] s;
      logic        tr;
      tr = force_trig || (probe_valid && trig_en && probe_data[31:0] == trig_pc);
      if (rst) begin
        ms = 0; w = 0; post = 0; movf = 1'b0; q = {};
      end else if (ms == 0) begin
        if (arm) begin ms = 1; q = {}; movf = 1'b0; end
      end else if (ms == 1 || ms == 2) begin
        if (probe_valid) begin
          if (q.size() == 8) begin void'(q.pop_front()); movf = 1'b1; end
          q.push_back(probe_data);
        end
        if (ms == 1 && tr) begin
          post = PT; w = 0; ms = PT == 0 ? 3 : 2;
        end else if (ms == 2 && probe_valid) begin
          post--;
          if (post == 0) begin ms = 3; w = 0; end
        end
      end else begin
        if (arm) begin ms = 1; q = {}; movf = 1'b0; end
        else if (q.size() == 0) ms = 0;
        else if (rd_ready) begin
          if (w == q.size() * 2 - 1) ms = 0;
          else w++;
        end
      end
      e.valid = ms == 3 && q.size() > 0;
      s = e.valid ? q[w / 2] : 64'd0;
      e.data = (w % 2) == 1 ? s[63:32] : s[31:0];
      e.ch   = e.valid && (w % 2) == 1;
      e.last = e.valid && w == q.size() * 2 - 1;
      e.st   = 2'(ms);
      e.fill = 4'(q.size());
      e.ovf  = movf;
    end
  end
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic chk_lane(input int g, input exp_t e, input logic v, input logic [31:0] d,
                          input logic c, input logic l, input logic [1:0] s, input logic [3:0] f,
                          input logic o);
    chk($sformatf("L%0d_state", g), 64'(s), 64'(e.st));
    chk($sformatf("L%0d_fill", g), 64'(f), 64'(e.fill));
    chk($sformatf("L%0d_ovf", g), 64'(o), 64'(e.ovf));
    chk($sformatf("L%0d_rd", g), {29'd0, v, c, l, d}, {29'd0, e.valid, e.ch, e.last, e.data});
  endtask
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    chk_lane(0, lane[0].e, rd_valid[0], rd_data[0], rd_ch[0], rd_last[0], st[0], fc[0], ovf[0]);
    chk_lane(1, lane[1].e, rd_valid[1], rd_data[1], rd_ch[1], rd_last[1], st[1], fc[1], ovf[1]);
  endtask
  task automatic cyc();
    if (rd_valid[0] && rd_ready) got0.push_back({rd_last[0], rd_data[0]});
    if (rd_valid[1] && rd_ready) got1.push_back({rd_last[1], rd_data[1]});
    tick();
  endtask
  task automatic set_pc(input logic [31:0] pc);
    probe_data = {~pc, pc};
  endtask
  task automatic capture(input logic [31:0] tpc, input int n);
    got0 = {}; got1 = {};
    trig_pc = tpc; trig_en = 1'b1; rd_ready = 1'b0;
    arm = 1'b1; cyc(); arm = 1'b0;
    for (int i = 0; i < n; i++) begin
      probe_valid = 1'b1; set_pc(32'(i * 4)); cyc();
    end
    probe_valid = 1'b0;
  endtask
  task automatic read_out(input int mode);
    int i;
    for (i = 0; i < 200; i++) begin
      if (st[0] == 2'd0 && st[1] == 2'd0) break;
      rd_ready = mode == 0 ? 1'b1 : mode == 1 ? ((i >= 6 && i < 11) ? 1'b0 : (i % 2) == 0) : 1'($urandom_range(0, 1));
      cyc();
    end
    rd_ready = 1'b0;
    chk("readout_timeout", 64'(i < 200), 64'd1);
  endtask
  task automatic chk_words(input string tag, input logic [32:0] got [$], input logic [31:0] pc0, input int n);
    chk({tag, "_count"}, 64'(got.size()), 64'(n));
    for (int i = 0; i < got.size() && i < n; i++) begin
      logic [31:0] pc;
      pc = pc0 + 32'(4 * (i / 2));
      chk($sformatf("%s_w%0d", tag, i), 64'(got[i]), {31'd0, i == n - 1, (i % 2) == 1 ? ~pc : pc});
    end
  endtask
  initial begin
    rst = 1'b1; probe_valid = 1'b0; probe_data = '0; arm = 1'b0; trig_en = 1'b0;
    trig_pc = '0; force_trig = 1'b0; rd_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    chk("reset_state", 64'(st[0]), 64'd0);
    chk("reset_rd_valid", 64'(rd_valid[0]), 64'd0);
    arm = 1'b1; cyc(); arm = 1'b0;
    for (int i = 0; i < 4; i++) begin probe_valid = 1'b1; set_pc(32'(i * 4)); cyc(); end
    rst = 1'b1; cyc(); cyc(); rst = 1'b0; probe_valid = 1'b0;
    chk("rst_mid_state", 64'(st[0]), 64'd0);
    chk("rst_mid_fill", 64'(fc[0]), 64'd0);
    chk("rst_mid_ovf", 64'(ovf[0]), 64'd0);
    chk("rst_mid_rd_valid", 64'(rd_valid[0]), 64'd0);
    capture(32'h28, 20);
    chk("s2_state", 64'(st[0]), 64'd3);
    chk("s2_fill", 64'(fc[0]), 64'd8);
    chk("s2_ovf", 64'(ovf[0]), 64'd1);
    read_out(0);
    chk_words("s2_l0", got0, 32'h14, 16);
    chk_words("s2_l1", got1, 32'h0C, 16);
    capture(32'h08, 5);
    chk("s3_fill", 64'(fc[0]), 64'd5);
    chk("s3_ovf", 64'(ovf[0]), 64'd0);
    read_out(2);
    chk_words("s3_l0", got0, 32'h00, 10);
    chk_words("s3_l1", got1, 32'h00, 6);
    chk("s3_idle", 64'(st[0]), 64'd0);
    capture(32'h28, 20);
    read_out(1);
    chk_words("s4_l0", got0, 32'h14, 16);
    got0 = {}; got1 = {};
    trig_en = 1'b0; rd_ready = 1'b1;
    arm = 1'b1; cyc(); arm = 1'b0;
    for (int i = 0; i < 24; i++) begin
      probe_valid = (i % 4) == 0;
      set_pc(32'h100 + 32'(4 * (i / 4)));
      force_trig = i == 9;
      cyc();
    end
    probe_valid = 1'b0; force_trig = 1'b0;
    read_out(0);
    chk_words("s5_l1", got1, 32'h100, 6);
    chk_words("s5_l0", got0, 32'h100, 10);
    capture(32'h28, 20);
    rd_ready = 1'b1;
    for (int i = 0; i < 5; i++) cyc();
    rd_ready = 1'b0;
    chk("s6_words_read", 64'(got0.size()), 64'd5);
    arm = 1'b1; cyc(); arm = 1'b0;
    chk("s6_rearm_state", 64'(st[0]), 64'd1);
    chk("s6_rearm_fill", 64'(fc[0]), 64'd0);
    for (int i = 8; i < 12; i++) begin probe_valid = 1'b1; set_pc(32'(i * 4)); cyc(); end
    probe_valid = 1'b0;
    chk("s6_post_state", 64'(st[0]), 64'd2);
    rst = 1'b1; cyc(); rst = 1'b0;
    chk("s6_rst_state", 64'(st[0]), 64'd0);
    capture(32'h08, 5);
    read_out(0);
    chk_words("s6_l0", got0, 32'h00, 10);
    trig_pc = 32'h20;
    for (int i = 0; i < 800; i++) begin
      rst         = $urandom_range(0, 299) == 0;
      arm         = $urandom_range(0, 29) == 0;
      probe_valid = $urandom_range(0, 2) != 0;
      set_pc({26'd0, 4'($urandom_range(0, 15)), 2'b00});
      trig_en     = 1'($urandom_range(0, 1));
      force_trig  = $urandom_range(0, 49) == 0;
      rd_ready    = 1'($urandom_range(0, 1));
      cyc();
    end
    rst = 1'b0; arm = 1'b0; probe_valid = 1'b0; force_trig = 1'b0; trig_en = 1'b0;
    for (int i = 0; i < 4; i++) cyc();
    rst = 1'b1; cyc(); rst = 1'b0;
    chk("final_state", 64'(st[0]), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
